// File: rtl/palindrome_window_detector.sv
// Serial-bit palindrome detector over a runtime-length sliding window (2..MAX_LEN).
// Optional saturating match counter is built when PALIN_MATCH_CNT_EN is defined.
module palindrome_window_detector #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           cfg_load,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           in_valid,
    input  logic                           in,
    output logic                           filled,
    output logic                           match_valid,
    output logic                           match,
    output logic [CNT_W-1:0]               match_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] win;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;

    logic               accept;
    logic               eval;
    logic               pal;
    logic [MAX_LEN-1:0] win_next;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   half;
    logic [LEN_W-1:0]   mirror;

    assign accept    = enable & in_valid & ~cfg_load;
    assign win_next  = {win[MAX_LEN-2:0], in};
    assign fill_next = (fill < len) ? fill + LEN_W'(1) : len;
    assign eval      = accept & (fill_next == len);

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len < LEN_W'(2)) begin
            len_clamped = LEN_W'(2);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Compare the post-shift window against its mirror about the active length.
    always_comb begin
        pal    = 1'b1;
        half   = len >> 1;
        mirror = '0;
        for (int i = 0; i < int'(MAX_LEN / 2); i++) begin
            if (LEN_W'(i) < half) begin
                mirror = len - LEN_W'(1) - LEN_W'(i);
                if (win_next[i] != win_next[IDX_W'(mirror)]) begin
                    pal = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            win         <= '0;
            len         <= LEN_W'(MAX_LEN);
            fill        <= '0;
            filled      <= 1'b0;
            match_valid <= 1'b0;
            match       <= 1'b0;
        end else if (cfg_load) begin
            state       <= enable ? FILL : IDLE;
            win         <= '0;
            len         <= len_clamped;
            fill        <= '0;
            filled      <= 1'b0;
            match_valid <= 1'b0;
            match       <= 1'b0;
        end else if (accept) begin
            win         <= win_next;
            fill        <= fill_next;
            filled      <= (fill_next == len);
            state       <= (fill_next == len) ? RUN : FILL;
            match_valid <= eval;
            if (eval) begin
                match <= pal;
            end
        end else begin
            match_valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                state <= (fill < len) ? FILL : RUN;
            end
        end
    end

`ifdef PALIN_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of positive evaluations; restarts with each new configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cfg_load) begin
            cnt <= '0;
        end else if (eval && pal && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_palindrome_window_detector.sv
// Directed bench for palindrome_window_detector at MAX_LEN=8, CNT_W=4.
module tb_palindrome_window_detector;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             cfg_load;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_bit;
    logic             filled;
    logic             match_valid;
    logic             match;
    logic [CNT_W-1:0] match_count;

    int checks   = 0;
    int failures = 0;

    palindrome_window_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_len     (cfg_len),
        .in_valid    (in_valid),
        .in          (in_bit),
        .filled      (filled),
        .match_valid (match_valid),
        .match       (match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int f, input int mv, input int m);
        chk({tag, ".filled"}, int'(filled), f);
        chk({tag, ".match_valid"}, int'(match_valid), mv);
        chk({tag, ".match"}, int'(match), m);
    endtask

    // One clock with the given bit; sampled 1ns after the capturing edge.
    task automatic drive(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int l, input logic v, input logic b);
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_len  = LEN_W'(l);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        reset_n  = 1'b0;
        enable   = 1'b0;
        cfg_load = 1'b0;
        cfg_len  = '0;
        in_valid = 1'b0;
        in_bit   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0);
        chk("reset.count", int'(match_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Default length 8 after reset: 10011001 is a palindrome.
        pat = 8'b10011001;
        for (int i = 0; i < 7; i++) drive(1'b1, pat[7-i]);
        chk_out("len8_bit7", 0, 0, 0);
        drive(1'b1, pat[0]);
        chk_out("len8_bit8", 1, 1, 1);

        // Asynchronous reset mid-stream clears outputs immediately.
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("midreset", 0, 0, 0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Length 4.
        load(4, 1'b0, 1'b0);
        chk_out("load4", 0, 0, 0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk_out("len4_bit3", 0, 0, 0);
        drive(1'b1, 1'b1);
        chk_out("len4_bit4", 1, 1, 1);
        drive(1'b1, 1'b1);
        chk_out("len4_bit5", 1, 1, 0);
        drive(1'b0, 1'b0);
        chk_out("len4_idle", 1, 0, 0);

        // Length 5, odd: middle bit ignored.
        load(5, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk_out("len5_bit4", 0, 0, 0);
        drive(1'b1, 1'b1);
        chk_out("len5_bit5", 1, 1, 1);
        drive(1'b1, 1'b0);
        chk_out("len5_bit6", 1, 1, 0);

        // cfg_len=0 clamps to 2.
        load(0, 1'b0, 1'b0);
        drive(1'b1, 1'b1);
        chk_out("len2_bit1", 0, 0, 0);
        drive(1'b1, 1'b1);
        chk_out("len2_bit2", 1, 1, 1);
        drive(1'b1, 1'b0);
        chk_out("len2_bit3", 1, 1, 0);

        // cfg_len=12 clamps to 8.
        load(12, 1'b0, 1'b0);
        pat = 8'b01100110;
        for (int i = 0; i < 7; i++) drive(1'b1, pat[7-i]);
        chk_out("len12_bit7", 0, 0, 0);
        drive(1'b1, pat[0]);
        chk_out("len12_bit8", 1, 1, 1);

        // A bit presented with cfg_load is dropped.
        load(2, 1'b1, 1'b1);
        chk_out("drop_load", 0, 0, 0);
        drive(1'b1, 1'b1);
        chk_out("drop_bit1", 0, 0, 0);
        drive(1'b1, 1'b1);
        chk_out("drop_bit2", 1, 1, 1);

        // Hold for 10 cycles between bits 2 and 3 of a length-4 stream.
        load(4, 1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            enable   = 1'b0;
            in_valid = 1'b1;
            in_bit   = 1'(i);
            @(posedge clk);
            #1;
        end
        chk_out("hold_end", 0, 0, 0);
        enable = 1'b1;
        drive(1'b1, 1'b1);
        chk_out("resume_bit3", 0, 0, 0);
        drive(1'b1, 1'b0);
        chk_out("resume_bit4", 1, 1, 1);

        // Counter: 20 consecutive matches at length 2.
        load(2, 1'b0, 1'b0);
        chk("cnt_cleared", int'(match_count), 0);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
`ifdef PALIN_MATCH_CNT_EN
        chk("cnt_after5", int'(match_count), 5);
`else
        chk("cnt_after5", int'(match_count), 0);
`endif
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b1);
        chk_out("cnt_last", 1, 1, 1);
`ifdef PALIN_MATCH_CNT_EN
        chk("cnt_sat", int'(match_count), 15);
`else
        chk("cnt_sat", int'(match_count), 0);
`endif
        load(3, 1'b0, 1'b0);
        chk("cnt_reload", int'(match_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
